// File: rtl/ppfifo_stream_writer_if.sv
// Bundle of the stream-side handshake and the ping-pong FIFO write port.
// The master side is the producer/FIFO environment; the slave side is the writer.
interface ppfifo_stream_writer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_last;
  logic [1:0]            write_ready;
  logic [1:0]            write_activate;
  logic [23:0]           write_fifo_size;
  logic                  write_strobe;
  logic [DATA_WIDTH-1:0] write_data;
  logic [23:0]           o_count;

  modport master (
    output i_valid, i_data, i_last, write_ready, write_fifo_size,
    input  i_ready, write_activate, write_strobe, write_data, o_count
  );

  modport slave (
    input  i_valid, i_data, i_last, write_ready, write_fifo_size,
    output i_ready, write_activate, write_strobe, write_data, o_count
  );
endinterface

// File: rtl/ppfifo_stream_writer.sv
// Producer-side adapter: claims one free ping-pong buffer at a time, streams
// words into it, and releases it when full, on a last marker, or after an
// idle timeout with a partially filled buffer.
module ppfifo_stream_writer #(
  parameter int DATA_WIDTH   = 32,
  parameter int IDLE_TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   rst,
  ppfifo_stream_writer_if.slave bus
);
  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
  // Release is decided on the edge where the counter would reach IDLE_TIMEOUT,
  // so the claim drops IDLE_TIMEOUT+1 cycles after the last strobe.
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RELEASE
  } state_t;

  state_t      state;
  logic        ready_q;
  logic [1:0]  activate_q;
  logic        last_used;
  logic [23:0] count_q;
  logic [23:0] size_q;
  logic [IW-1:0] idle_cnt;

  logic strobe;
  logic word_ends;
  logic claim_buf;

  assign strobe    = bus.i_valid & ready_q;
  assign word_ends = strobe & (((count_q + 24'd1) == size_q) | bus.i_last);

  assign bus.i_ready        = ready_q;
  assign bus.write_activate = activate_q;
  assign bus.write_strobe   = strobe;
  assign bus.write_data     = DATA_WIDTH'(bus.i_data);
  assign bus.o_count        = count_q;

  // Buffer selection: a lone free buffer wins, otherwise alternate.
  always_comb begin
    claim_buf = ~last_used;
    case (bus.write_ready)
      2'b01:   claim_buf = 1'b0;
      2'b10:   claim_buf = 1'b1;
      default: claim_buf = ~last_used;
    endcase
  end

  // Claim / fill / release sequencing with registered claim and ready outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ready_q    <= 1'b0;
      activate_q <= '0;
      last_used  <= 1'b1;
      count_q    <= '0;
      size_q     <= '0;
      idle_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.write_ready != 2'b00 && bus.write_fifo_size != '0) begin
            state      <= ACTIVE;
            ready_q    <= 1'b1;
            activate_q <= claim_buf ? 2'b10 : 2'b01;
            last_used  <= claim_buf;
            count_q    <= '0;
            size_q     <= bus.write_fifo_size;
            idle_cnt   <= '0;
          end
        end
        ACTIVE: begin
          if (strobe) begin
            count_q  <= count_q + 24'd1;
            idle_cnt <= '0;
            if (word_ends) begin
              state      <= RELEASE;
              ready_q    <= 1'b0;
              activate_q <= '0;
            end
          end else begin
            if (idle_cnt != IDLE_LAST) begin
              idle_cnt <= idle_cnt + 1'b1;
            end
            if (idle_cnt == IDLE_LAST && count_q != '0) begin
              state      <= RELEASE;
              ready_q    <= 1'b0;
              activate_q <= '0;
            end
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ppfifo_stream_writer.sv
// Scoreboard bench: the stimulus side predicts, per accepted word, which buffer
// it lands in and its position there; a negedge monitor checks every strobe.
module tb_ppfifo_stream_writer;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ppfifo_stream_writer_if #(.DATA_WIDTH(32)) bus ();

  ppfifo_stream_writer #(
    .DATA_WIDTH  (32),
    .IDLE_TIMEOUT(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  act;
    logic [23:0] cnt;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   e;
  int     errors = 0;
  int     checks = 0;
  int     strobes = 0;
  longint cyc = 0;
  longint strobe_cyc[$];

  // Reference model: buffer occupancy tracked per packet rules.
  logic [1:0] m_ready;
  int         m_size;
  bit         m_open;
  int         m_buf;
  int         m_cnt;
  int         m_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic void model_word(input logic [31:0] d, input bit l, input int gap);
    exp_t x;
    if (m_open && m_cnt > 0 && gap >= T) m_open = 0;
    if (!m_open) begin
      if (m_ready == 2'b11) m_buf = 1 - m_last;
      else if (m_ready == 2'b10) m_buf = 1;
      else m_buf = 0;
      m_last = m_buf;
      m_open = 1;
      m_cnt  = 0;
    end
    x.data = d;
    x.act  = (m_buf == 1) ? 2'b10 : 2'b01;
    x.cnt  = 24'(m_cnt);
    exp_q.push_back(x);
    m_cnt++;
    if (m_cnt == m_size || l) m_open = 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!rst && bus.write_strobe === 1'b1) begin
      strobes++;
      strobe_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got data %0h with activate %b, required no strobe",
                 bus.write_data, bus.write_activate);
      end else begin
        e = exp_q.pop_front();
        chk("write_data", 64'(bus.write_data), 64'(e.data));
        chk("write_activate", 64'(bus.write_activate), 64'(e.act));
        chk("o_count_at_strobe", 64'(bus.o_count), 64'(e.cnt));
      end
    end
  end

  task automatic idle_inputs();
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    bus.i_data  = '0;
  endtask

  task automatic do_reset(input logic [1:0] r, input int size);
    idle_inputs();
    rst = 1'b1;
    bus.write_ready     = r;
    bus.write_fifo_size = 24'(size);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    m_ready = r;
    m_size  = size;
    m_open  = 0;
    m_last  = 1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input bit l, input int gap);
    int unsigned waited;
    waited = 0;
    idle_inputs();
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_last  = l;
    while (bus.i_ready !== 1'b1) begin
      @(posedge clk);
      #1;
      waited++;
      if (waited > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_wait: word %0h not accepted after %0d cycles, required acceptance", d, waited);
        idle_inputs();
        return;
      end
    end
    model_word(d, l, gap);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int held;
    int s0;
    int n;
    int gaps[8];
    logic [1:0] rsel[3];
    gaps = '{0, 0, 0, 1, 2, T - 1, T, T + 2};
    rsel = '{2'b01, 2'b10, 2'b11};

    // Reset with a word offered and both buffers free.
    bus.i_valid = 1'b1;
    bus.i_last  = 1'b0;
    bus.i_data  = 32'h5;
    bus.write_ready     = 2'b11;
    bus.write_fifo_size = 24'd4;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_activate", 64'(bus.write_activate), 64'd0);
    chk("rst_i_ready", 64'(bus.i_ready), 64'd0);
    chk("rst_strobe", 64'(bus.write_strobe), 64'd0);
    chk("rst_o_count", 64'(bus.o_count), 64'd0);
    idle_inputs();
    m_ready = 2'b11; m_size = 4; m_open = 0; m_last = 1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_claim", 64'(bus.write_activate), 64'h1);
    chk("first_ready", 64'(bus.i_ready), 64'h1);

    // Full fill: two buffers of 4 back to back.
    do_reset(2'b11, 4);
    strobe_cyc.delete();
    for (int unsigned i = 0; i < 8; i++) begin
      send(32'h10 + 32'(i), 1'b0, 0);
      if (i == 3 || i == 7) begin
        chk("full_o_count", 64'(bus.o_count), 64'd4);
        chk("full_release", 64'(bus.write_activate), 64'd0);
      end
    end
    chk("full_strobes", 64'(strobe_cyc.size()), 64'd8);
    if (strobe_cyc.size() == 8) begin
      chk("throughput", 64'(strobe_cyc[1] - strobe_cyc[0]), 64'd1);
      chk("bubble_a", 64'(strobe_cyc[4] - strobe_cyc[3]), 64'd3);
      chk("span_b", 64'(strobe_cyc[7] - strobe_cyc[4]), 64'd3);
    end

    // Last marker on the second word.
    do_reset(2'b11, 8);
    send(32'h20, 1'b0, 0);
    send(32'h21, 1'b1, 0);
    chk("last_o_count", 64'(bus.o_count), 64'd2);
    chk("last_release", 64'(bus.write_activate), 64'd0);
    send(32'h22, 1'b0, 0);

    // Timeout after three words.
    do_reset(2'b11, 8);
    for (int unsigned i = 0; i < 3; i++) send(32'h60 + 32'(i), 1'b0, 0);
    lat = 1;
    while (bus.write_activate != 2'b00 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("timeout_latency", 64'(lat), 64'(T + 1));
    chk("timeout_o_count", 64'(bus.o_count), 64'd3);

    // Empty claim is never timed out.
    do_reset(2'b11, 8);
    @(posedge clk);
    #1;
    held = 0;
    for (int unsigned i = 0; i < 120; i++) begin
      if (bus.write_activate == 2'b01) held++;
      @(posedge clk);
      #1;
    end
    chk("empty_hold", 64'(held), 64'd120);

    // No buffer free.
    do_reset(2'b00, 4);
    bus.i_valid = 1'b1;
    bus.i_data  = 32'hdead;
    s0 = strobes;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("nofree_i_ready", 64'(bus.i_ready), 64'd0);
    chk("nofree_activate", 64'(bus.write_activate), 64'd0);
    chk("nofree_strobes", 64'(strobes - s0), 64'd0);
    idle_inputs();
    bus.write_ready = 2'b10;
    m_ready = 2'b10;
    @(posedge clk);
    #1;
    chk("late_claim", 64'(bus.write_activate), 64'h2);
    send(32'h30, 1'b0, 0);

    // Asynchronous reset in the middle of a buffer.
    do_reset(2'b11, 8);
    send(32'h40, 1'b0, 0);
    send(32'h41, 1'b0, 0);
    chk("mid_o_count", 64'(bus.o_count), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_activate", 64'(bus.write_activate), 64'd0);
    chk("mid_rst_o_count", 64'(bus.o_count), 64'd0);
    chk("mid_rst_i_ready", 64'(bus.i_ready), 64'd0);
    @(posedge clk);
    #1;
    do_reset(2'b11, 8);
    send(32'h50, 1'b0, 0);

    // Randomised segments against the model.
    for (int unsigned seg = 0; seg < 6; seg++) begin
      do_reset(rsel[$urandom_range(0, 2)], int'($urandom_range(1, 6)));
      n = int'($urandom_range(15, 30));
      for (int unsigned i = 0; i < 32'(n); i++) begin
        send($urandom, ($urandom_range(0, 5) == 0), gaps[$urandom_range(0, 7)]);
      end
      @(posedge clk);
      #1;
      chk("segment_drained", 64'(exp_q.size()), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
